// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch.
// Keeps the fetch PC, runs the imem request/response handshake, and holds
// returned words in a 2-entry in-order queue whose head feeds decode.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   imem_req_valid/ready      request handshake; imem_addr = fetch PC
//   imem_rsp_valid/data       in-order response, one per accepted request
//   stall                     decode holds the head
//   flush, redirect_pc        branch/jump redirect
//   valid, instr, pc_out      queue head (bubble 0x00000013 / pc 0 when empty)
//   operation, nop            {funct7, funct3, opcode} of the head, !valid
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [16:0] operation,
  output logic        nop
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  entry_t      q [2];
  logic        head, tail;
  logic [1:0]  count, outstanding, drop_cnt;
  logic [31:0] pc, rsp_pc;

  logic        pop, accept, push;
  logic [2:0]  occ;

  assign valid = (count != 2'd0);
  assign pop   = valid && !stall && !flush;

  // Slots committed = in-flight requests + held words. The head leaving this
  // cycle frees its slot before any new response can land (latency >= 1),
  // so it is credited; without that credit a 1-cycle memory could only
  // sustain one instruction every other cycle.
  assign occ = {1'b0, outstanding} + {1'b0, count} - {2'b00, pop};

  assign imem_req_valid = !rst && !flush && (occ < 3'd2);
  assign imem_addr      = pc;
  assign accept         = imem_req_valid && imem_req_ready;

  // Responses owed to a pre-flush PC stream are swallowed, not queued.
  assign push = imem_rsp_valid && (drop_cnt == 2'd0) && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      head        <= 1'b0;
      tail        <= 1'b0;
      count       <= 2'd0;
      outstanding <= 2'd0;
      drop_cnt    <= 2'd0;
    end else begin
      outstanding <= outstanding + {1'b0, accept} - {1'b0, imem_rsp_valid};
      if (flush) begin
        // Everything still in flight belongs to the old path, including
        // nothing arriving this cycle (that one is already being ignored).
        count    <= 2'd0;
        head     <= 1'b0;
        tail     <= 1'b0;
        pc       <= redirect_pc;
        rsp_pc   <= redirect_pc;
        drop_cnt <= outstanding - {1'b0, imem_rsp_valid};
      end else begin
        if (accept) pc <= pc + 32'd4;
        if (imem_rsp_valid && drop_cnt != 2'd0) drop_cnt <= drop_cnt - 2'd1;
        if (push) begin
          q[tail] <= '{instr: imem_rsp_data, pc: rsp_pc};
          tail    <= ~tail;
          rsp_pc  <= rsp_pc + 32'd4;
        end
        if (pop) head <= ~head;
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  // The issue credit rule makes a push into a full queue unreachable.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && count == 2'd2));
  end

  assign instr     = valid ? q[head].instr : NOP_WORD;
  assign pc_out    = valid ? q[head].pc : 32'h0;
  assign operation = {instr[31:25], instr[14:12], instr[6:0]};
  assign nop       = !valid;

endmodule
